// File: rtl/sram_pkg.sv
// Shared types for the SRAM bank controller: FSM state encoding, the
// captured-request control record and the byte-lane parity helper.
// Optional feature macro: SRAM_PARITY_EN (per-lane even parity).
package sram_pkg;

  // Controller sequence: wait for a request, touch the array, report.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Width-independent part of an accepted request. Address, byte enables
  // and write data depend on the controller parameters, so they are held
  // in parameter-sized registers next to this record.
  typedef struct packed {
    logic write;
    logic oob;
  } req_ctrl_t;

  // Even parity for one byte lane: the stored bit makes the 9-bit group
  // carry an even number of ones.
  function automatic logic even_parity(input logic [7:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Synchronous single-port word array with per-byte-lane write enables and
// a registered read port. The read register only changes on a read, so it
// keeps the last read word across writes and idle cycles.
// Optional feature macro: SRAM_PARITY_EN adds one stored parity bit per
// lane, written alongside that lane and read back with the data.
module sram_array
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_PARITY_EN
  output logic [BE_W-1:0]   rpar,
`endif
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Data storage: lane-masked write or full-word registered read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

`ifdef SRAM_PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];

  // Parity storage tracks the data lanes exactly, including the read register.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            par_mem[addr][i] <= even_parity(wdata[8*i +: 8]);
          end
        end
      end else begin
        rpar <= par_mem[addr];
      end
    end
  end
`endif

endmodule

// File: rtl/sram_bank_ctrl.sv
// Request/response front end for one SRAM bank. A request is captured in
// IDLE, the array is accessed one cycle later, and completion is flagged
// in the following cycle, giving one access in flight at a time.
// Optional feature macro: SRAM_PARITY_EN (parity check on reads).
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              flg_complete
);

  // One extra bit so the limit is representable when DEPTH is a power of 2.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  req_ctrl_t         req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              zero_rdata;
  logic              arr_en;
  logic [DATA_W-1:0] arr_rdata;
  logic              par_err;

  assign accept = req_valid && req_ready;

  // State register; reset aborts any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/completion outputs.
  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    flg_complete = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
      end
      RESP: begin
        flg_complete = 1'b1;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture the request at acceptance; inputs are ignored afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q   <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      req_q.write <= req_write;
      req_q.oob   <= ({1'b0, req_addr} >= DEPTH_EXT);
      addr_q      <= req_addr;
      be_q        <= req_be;
      wdata_q     <= req_wdata;
    end
  end

  // Out-of-range accesses never reach the array, so nothing is written.
  assign arr_en = (state == ACCESS) && !req_q.oob;

  // Remembers whether the most recent read was out of range (or none has
  // happened since reset) so the response reads as zero until the next read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_rdata <= 1'b1;
    end else if ((state == ACCESS) && !req_q.write) begin
      zero_rdata <= req_q.oob;
    end
  end

  assign rsp_rdata = zero_rdata ? '0 : arr_rdata;

`ifdef SRAM_PARITY_EN
  logic [BE_W-1:0] arr_par;

  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (req_q.write),
    .be    (be_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rpar  (arr_par),
    .rdata (arr_rdata)
  );

  // Recompute parity on every lane of an in-range read result.
  always_comb begin
    par_err = 1'b0;
    if (!req_q.write && !req_q.oob) begin
      for (int i = 0; i < BE_W; i++) begin
        if (even_parity(arr_rdata[8*i +: 8]) != arr_par[i]) begin
          par_err = 1'b1;
        end
      end
    end
  end
`else
  sram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (req_q.write),
    .be    (be_q),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Without stored parity only the range check can flag an error.
  always_comb begin
    par_err = 1'b0;
  end
`endif

  assign rsp_err = flg_complete && (req_q.oob || par_err);

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Self-checking bench for sram_bank_ctrl built with DEPTH = 100 so the
// out-of-range path is reachable. Table-driven transactions plus directed
// sequences for back-to-back handshake, reset abort and range sweep.
module tb_sram_bank_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 100;
  localparam int ADDR_W = 7;
  localparam int BE_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              flg_complete;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs [15];

  sram_bank_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_be       (req_be),
    .req_wdata    (req_wdata),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .flg_complete (flg_complete)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transaction: drive at a falling edge, drop the request
  // (scrambling the fields) once accepted, wait for the completion pulse,
  // then confirm the block is idle again one cycle later.
  task automatic applyStimulus(input logic write, input logic [ADDR_W-1:0] addr,
                               input logic [BE_W-1:0] be, input logic [DATA_W-1:0] wdata,
                               output logic [DATA_W-1:0] rdata, output logic err);
    int lat;
    @(negedge clk);
    checkOutput("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wdata;
    lat   = -1;
    rdata = '0;
    err   = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) begin
        req_valid = 1'b0;
        req_write = ~write;
        req_addr  = addr ^ 7'h2A;
        req_be    = ~be;
        req_wdata = ~wdata;
      end
      if (flg_complete) begin
        lat   = i;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
    end
    checkOutput("complete_latency", 32'(lat), 32'd2);
    @(negedge clk);
    checkOutput("complete_one_cycle", 32'(flg_complete), 32'd0);
    checkOutput("err_outside_complete", 32'(rsp_err), 32'd0);
    checkOutput("ready_after_complete", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [DATA_W-1:0] sweepPattern(input int i);
    return 32'h9E3779B9 * 32'(i + 1) ^ 32'h5A5A0000;
  endfunction

  initial begin
    logic [DATA_W-1:0] rd;
    logic              er;
    int                acc;

    vecs[0]  = '{1'b1, 7'd5,   4'hF, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 7'd5,   4'h0, 32'h00000000, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 7'd9,   4'hF, 32'h11223344, 32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b1, 7'd9,   4'h5, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 7'd9,   4'h0, 32'h00000000, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b1, 7'd9,   4'h0, 32'hFFFFFFFF, 32'h11BB33DD, 1'b0};
    vecs[6]  = '{1'b0, 7'd9,   4'h0, 32'h00000000, 32'h11BB33DD, 1'b0};
    vecs[7]  = '{1'b0, 7'd100, 4'h0, 32'h00000000, 32'h00000000, 1'b1};
    vecs[8]  = '{1'b1, 7'd5,   4'h8, 32'h12000000, 32'h00000000, 1'b0};
    vecs[9]  = '{1'b0, 7'd5,   4'h0, 32'h00000000, 32'h12ADBEEF, 1'b0};
    vecs[10] = '{1'b1, 7'd99,  4'hF, 32'hCAFEF00D, 32'h12ADBEEF, 1'b0};
    vecs[11] = '{1'b0, 7'd99,  4'h0, 32'h00000000, 32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b1, 7'd0,   4'hF, 32'h01020304, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{1'b0, 7'd0,   4'h0, 32'h00000000, 32'h01020304, 1'b0};
    vecs[14] = '{1'b1, 7'd120, 4'hF, 32'hFFFFFFFF, 32'h01020304, 1'b1};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_complete", 32'(flg_complete), 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);
    checkOutput("reset_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;

    $display("[TB] table-driven transactions");
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].write, vecs[v].addr, vecs[v].be, vecs[v].wdata, rd, er);
      checkOutput($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
      checkOutput($sformatf("vec%0d_err", v), 32'(er), 32'(vecs[v].exp_err));
    end

    $display("[TB] back-to-back handshake");
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("hs%0d_ready", i), 32'(req_ready), 32'((i % 3) == 0));
      checkOutput($sformatf("hs%0d_complete", i), 32'(flg_complete), 32'((i % 3) == 2));
      if (req_ready) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_be    = 4'hF;
        req_addr  = 7'(20 + acc);
        req_wdata = 32'hC0DE0000 + 32'(acc);
        acc++;
      end else begin
        req_addr  = 7'd50;
        req_wdata = 32'hFFFFFFFF;
      end
    end
    req_valid = 1'b0;
    checkOutput("hs_accept_count", 32'(acc), 32'd3);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(1'b0, 7'(20 + n), 4'h0, 32'h0, rd, er);
      checkOutput($sformatf("hs_read%0d", n), rd, 32'hC0DE0000 + 32'(n));
    end

    $display("[TB] reset during access");
    applyStimulus(1'b1, 7'd3, 4'hF, 32'h33333333, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 7'd3;
    req_be    = 4'hF;
    req_wdata = 32'hBAD0BAD0;
    @(posedge clk);
    #2;
    rst       = 1'b1;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_complete", 32'(flg_complete), 32'd0);
      checkOutput("abort_ready", 32'(req_ready), 32'd1);
      checkOutput("abort_rdata", rsp_rdata, 32'd0);
    end
    rst = 1'b0;
    applyStimulus(1'b0, 7'd3, 4'h0, 32'h0, rd, er);
    checkOutput("abort_addr3_kept", rd, 32'h33333333);

    $display("[TB] out-of-range write sweep");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 7'(i), 4'hF, sweepPattern(i), rd, er);
    end
    applyStimulus(1'b1, 7'd120, 4'hF, 32'h0BADF00D, rd, er);
    checkOutput("oob_write_err", 32'(er), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 7'(i), 4'h0, 32'h0, rd, er);
      checkOutput($sformatf("sweep%0d_rdata", i), rd, sweepPattern(i));
      checkOutput($sformatf("sweep%0d_err", i), 32'(er), 32'd0);
    end

`ifdef SRAM_PARITY_EN
    $display("[TB] parity error injection");
    applyStimulus(1'b1, 7'd7, 4'hF, 32'h0F0F0F0F, rd, er);
    applyStimulus(1'b1, 7'd8, 4'hF, 32'h01234567, rd, er);
    dut.u_array.par_mem[7][0] = ~dut.u_array.par_mem[7][0];
    applyStimulus(1'b0, 7'd7, 4'h0, 32'h0, rd, er);
    checkOutput("par_flip_err", 32'(er), 32'd1);
    checkOutput("par_flip_rdata", rd, 32'h0F0F0F0F);
    applyStimulus(1'b0, 7'd8, 4'h0, 32'h0, rd, er);
    checkOutput("par_clean_err", 32'(er), 32'd0);
    checkOutput("par_clean_rdata", rd, 32'h01234567);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_bank_ctrl.md
SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the word width in bits; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 128, giving the number of words; any value of 2 or more SHALL be legal.
REQ-003 The block SHALL have localparam ADDR_W = $clog2(DEPTH) and localparam BE_W = DATA_W/8.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-011 The block SHALL have port req_be, input, BE_W bits: byte-lane enables for writes (bit i maps to bits 8i+7:8i).
REQ-012 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: error status of the completing access.
REQ-015 The block SHALL have port flg_complete, output, 1 bit: one-cycle pulse marking completion of the access.

Function
REQ-016 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; req_write, req_addr, req_be and req_wdata SHALL be captured at that edge, and later changes to them SHALL be ignored.
REQ-017 The FSM SHALL have states IDLE, ACCESS and RESP with these transitions: IDLE to ACCESS on accept; ACCESS to RESP unconditionally; RESP to IDLE unconditionally.
REQ-018 req_ready SHALL be 1 only in IDLE, so at most one access is in flight and throughput is at most one access per 3 cycles.
REQ-019 Latency SHALL be as follows, for a request accepted at edge k:
  - the array is read or written at edge k+1;
  - flg_complete is 1 for exactly the cycle between edges k+1 and k+2;
  - req_ready returns to 1 after edge k+2.
REQ-020 A write SHALL update only the byte lanes whose req_be bit is 1; req_be = 0 SHALL leave memory unchanged and SHALL still complete normally.
REQ-021 A read SHALL return the full word on rsp_rdata, valid while flg_complete is 1.
REQ-022 rsp_rdata SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-023 An address >= DEPTH (possible only when DEPTH is not a power of 2) SHALL be handled as follows:
  - no write occurs;
  - rsp_rdata is loaded with 0;
  - rsp_err is 1 in the completion cycle.
REQ-024 rsp_err SHALL be 0 outside completion cycles.
REQ-025 A read of a word written earlier SHALL return the last written value of every lane.

Reset
REQ-026 While rst is 1, the block SHALL hold these output values: req_ready = 1, flg_complete = 0, rsp_err = 0, rsp_rdata = 0, and the FSM SHALL be in IDLE.
REQ-027 If rst is asserted before edge k+1, the in-flight access SHALL be aborted with no write and no completion pulse.
REQ-028 Memory contents SHALL NOT be cleared by reset; a read of a never-written word returns an undefined value.

Configuration
REQ-029 With macro SRAM_PARITY_EN defined, the block SHALL store one even-parity bit per byte lane, written alongside that lane.
REQ-030 With SRAM_PARITY_EN defined, a read SHALL recompute parity on all lanes and SHALL set rsp_err = 1 if any lane mismatches; rsp_rdata SHALL still return the stored data.
REQ-031 Without SRAM_PARITY_EN, the block SHALL have no parity storage, and rsp_err SHALL be raised only by the out-of-range condition.

Structure
REQ-032 Package sram_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and the captured-request struct type.
REQ-033 Storage SHALL be the sub-module sram_array (parameters DATA_W, DEPTH), a synchronous single-port array with per-lane write enable and registered read data, also holding parity bits when SRAM_PARITY_EN is defined.
REQ-034 The FSM, request capture and response logic SHALL reside in sram_bank_ctrl.

Verification
REQ-035 Full write then read: write addr 5, be 4'hF, data 32'hDEADBEEF, then read addr 5 -> rsp_rdata = 32'hDEADBEEF and flg_complete high exactly 2 cycles after accept.
REQ-036 Byte-lane merge: write 32'h11223344 to addr 9, then write be 4'b0101 with data 32'hAABBCCDD, then read addr 9 -> rsp_rdata = 32'h11BB33DD.
REQ-037 Handshake: hold req_valid = 1 continuously for 3 requests -> req_ready = 0 in ACCESS and RESP, accepts exactly 3 cycles apart, no request lost or duplicated.
REQ-038 Out of range: with DEPTH = 100, read addr 100 -> rsp_rdata = 0 and rsp_err = 1; write addr 120 followed by reads of all 100 words -> no word changed.
REQ-039 Reset mid-access: accept a write to addr 3, assert rst before the next edge -> no flg_complete pulse and addr 3 keeps its prior value.
REQ-040 Parity (SRAM_PARITY_EN defined): write addr 7, force one stored parity bit flipped, read addr 7 -> rsp_err = 1; an unflipped word -> rsp_err = 0.
